pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//  Sequences PLL bring-up and system reset release for the FPGA shell. Runs on the board
//  oscillator clock, drives PLL reset, qualifies pll_lock (sync + stability window), then
//  holds sys_reset for a fixed time before releasing ChipTop. Handles lock timeout with
//  bounded retries, lock loss while running, and a software/button retry request.
// PARAMETERS
//  PLL_RST_CYCLES      16        cycles pll_rst held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES 1000000   max cycles in WAIT_LOCK before an attempt fails
//  LOCK_STABLE_CYCLES  1024      consecutive synced-lock cycles required
//  HOLD_CYCLES         256       cycles sys_reset held after lock qualified
//  MAX_RETRIES         3         failed attempts allowed before FAIL
//  CNT_W               20        shared counter width; must hold max of the cycle params
//  SYNC_STAGES         2         pll_lock synchroniser depth (>=2)
// PORTS
//  clock_clock  in   1      board oscillator clock (not a PLL output)
//  reset        in   1      asynchronous, active-high reset
//  pll_lock     in   1      raw PLL lock, asynchronous to clock_clock
//  retry_req    in   1      synchronous 1-cycle pulse: force re-sequence
//  pll_rst      out  1      PLL reset, active high
//  sys_reset    out  1      ChipTop reset, active high; consumer re-syncs to its clock
//  ready        out  1      1 only in RUN
//  fail         out  1      1 only in FAIL
//  state        out  3      PLL_RST=0 WAIT_LOCK=1 STABLE=2 HOLD=3 RUN=4 FAIL=5
//  retry_cnt    out  2      failed attempts in current sequence ($clog2(MAX_RETRIES+1))
// BEHAVIOUR
//  - All outputs registered. While reset=1: state=PLL_RST, pll_rst=1, sys_reset=1,
//    ready=0, fail=0, retry_cnt=0, counter=0, sync chain=0.
//  - lock_s = pll_lock through SYNC_STAGES flops; FSM uses lock_s only.
//  - PLL_RST: pll_rst=1; after PLL_RST_CYCLES cycles -> WAIT_LOCK, counter=0.
//  - WAIT_LOCK: pll_rst=0. lock_s=1 -> STABLE, counter=0. Else counter++; at
//    LOCK_TIMEOUT_CYCLES-1: retry_cnt==MAX_RETRIES -> FAIL, else retry_cnt++ -> PLL_RST.
//  - STABLE: lock_s=0 -> WAIT_LOCK, counter=0 (timeout restarts; no retry consumed).
//    LOCK_STABLE_CYCLES consecutive lock_s=1 -> HOLD, counter=0.
//  - HOLD: sys_reset=1; after HOLD_CYCLES -> RUN, retry_cnt cleared.
//  - RUN: sys_reset=0, ready=1.
//  - Lock loss in HOLD/RUN (lock_s=0) -> PLL_RST next edge; sys_reset=1, ready=0 that edge.
//  - FAIL: pll_rst=1, sys_reset=1, fail=1; sticky until reset or retry_req.
//  - retry_req in FAIL or RUN -> PLL_RST, retry_cnt=0, counter=0. Ignored in other states.
//    Same cycle as lock loss in RUN: single transition to PLL_RST, retry_cnt=0.
//  - Timing, lock held high: sys_reset falls PLL_RST_CYCLES+1+LOCK_STABLE_CYCLES+
//    HOLD_CYCLES+1 edges after first edge with reset=0 (cycle-exact; bench checks it).
//  - Counter never wraps: every state exits at its terminal count; counter cleared on
//    every state change. Async reset mid-sequence returns everything to reset values.
// CONFIGURATION
//  PLL_SEQ_LOSS_CNT_EN defined: adds output loss_cnt [7:0], +1 per lock-loss event in
//    HOLD/RUN, saturates at 255, cleared only by reset (not by retry_req).
//  Undefined: loss_cnt port and logic absent; all other behaviour identical.
// TESTING (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8,
//          HOLD_CYCLES=4, MAX_RETRIES=2 unless noted)
//  1 pll_lock=1 throughout, release reset -> pll_rst low at edge 4, sys_reset low at
//    edge 18, ready=1, state=4.
//  2 pll_lock=0 forever -> 3 attempts of 4+32 cycles, retry_cnt 0->1->2, then state=5,
//    fail=1, pll_rst=1; retry_req pulse -> state=0, retry_cnt=0.
//  3 lock glitches low 1 cycle mid-STABLE -> back to WAIT_LOCK, retry_cnt unchanged,
//    sys_reset release delayed by glitch offset + 1 + 8.
//  4 in RUN drop pll_lock -> after sync delay sys_reset=1, ready=0, state=0; relock ->
//    full sequence again; with PLL_SEQ_LOSS_CNT_EN loss_cnt=1.
//  5 assert reset mid-HOLD -> all outputs to reset values immediately (async).
//  6 retry_req in RUN coincident with lock loss -> one entry to PLL_RST, retry_cnt=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: brings up the PLL from the board oscillator clock,
// qualifies its lock and holds sys_reset until the lock has been stable long
// enough. It also handles lock timeouts with bounded retries, lock loss while
// running, and software/button retry requests.
// Build option: define PLL_SEQ_LOSS_CNT_EN to add the loss_cnt output, which
// counts lock-loss events.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES         = 256,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 20,
  parameter int unsigned SYNC_STAGES         = 2,
  localparam int unsigned RC_W               = $clog2(MAX_RETRIES + 1)
) (
  input  logic            clock_clock,
  input  logic            reset,
  input  logic            pll_lock,
  input  logic            retry_req,
  output logic            pll_rst,
  output logic            sys_reset,
  output logic            ready,
  output logic            fail,
  output logic [2:0]      state,
  output logic [RC_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]      loss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  // Terminal counts. HOLD runs one edge past HOLD_CYCLES so that sys_reset
  // falls on the documented edge once the lock has been qualified.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [RC_W-1:0]  RC_MAX    = RC_W'(MAX_RETRIES);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RC_W-1:0]        retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   pll_rst_d, sys_reset_d, ready_d, fail_d;

  // Synchroniser for the raw, asynchronous pll_lock input.
  always_ff @(posedge clock_clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // State, shared counter, retry count and registered outputs.
  always_ff @(posedge clock_clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst   <= pll_rst_d;
      sys_reset <= sys_reset_d;
      ready     <= ready_d;
      fail      <= fail_d;
    end
  end

  // Next state, counter and retry count. The counter is cleared on every state
  // change; it is frozen in RUN and FAIL so that it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RC_MAX) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_PLL_RST;
            retry_d = retry_q + RC_W'(1);
          end
        end
      end
      S_STABLE: begin
        if (!lock_s)                state_d = S_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        // A retry request and a lock loss in the same cycle produce a single
        // entry to PLL_RST.
        if (!lock_s || retry_req) begin
          state_d = S_PLL_RST;
          retry_d = '0;
        end
      end
      S_FAIL: begin
        cnt_d = cnt_q;
        if (retry_req) begin
          state_d = S_PLL_RST;
          retry_d = '0;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode of the next state; the result is registered.
  always_comb begin
    pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAIL);
    sys_reset_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic loss_evt;
  assign loss_evt = ((state_q == S_HOLD) || (state_q == S_RUN)) && !lock_s;

  // Saturating count of lock-loss events; only reset clears it.
  always_ff @(posedge clock_clock or posedge reset) begin
    if (reset)                         loss_cnt <= '0;
    else if (loss_evt && loss_cnt != '1) loss_cnt <= loss_cnt + 8'd1;
  end
`endif

endmodule
